rotor_param: RTL and testbench

//  Parametrised successor of the single-rotor stage: one rotor stage of the enigma datapath.
//  - Programmable wiring table and programmable start/step/notch position.
//  - Forward (encode) and backward (decode) mapping.
//  - Valid/ready handshakes on input and output.
//  - Notch carry output, so stages can be chained into a rotor stack.

---
 rtl/rotor_param_if.sv | 25 ++
 rtl/rotor_param.sv | 219 +++++++++++++++++++++
 tb/tb_rotor_param.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rotor_param_if.sv
// Symbol stream bundle for one rotor stage: input handshake with map controls, and result handshake.
// The master modport is the upstream/downstream environment; the slave modport is the rotor stage.
interface rotor_param_if #(
    parameter int SYM_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [SYM_W-1:0] in_sym;
    logic             in_dec;
    logic             in_adv;
    logic             out_valid;
    logic             out_ready;
    logic [SYM_W-1:0] out_sym;
    logic             out_err;

    modport master (
        output in_valid, in_sym, in_dec, in_adv, out_ready,
        input  in_ready, out_valid, out_sym, out_err
    );

    modport slave (
        input  in_valid, in_sym, in_dec, in_adv, out_ready,
        output in_ready, out_valid, out_sym, out_err
    );
endinterface

// File: rtl/rotor_param.sv
// Programmable single rotor stage: forward/backward symbol substitution with stepping and notch carry.
// Optional macro ROTOR_INV_TABLE_EN keeps an inverse table so backward maps in one lookup instead of a scan.
module rotor_param #(
    parameter int SYM_W = 8,
    parameter int ALPHA = 26,
    parameter int BASE  = 65,
    parameter int POS_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [POS_W-1:0] cfg_addr,
    input  logic [POS_W-1:0] cfg_data,
    input  logic             cfg_load,
    input  logic [POS_W-1:0] cfg_start,
    input  logic [POS_W-1:0] cfg_step,
    input  logic [POS_W-1:0] cfg_notch,
    output logic             cfg_err,
    rotor_param_if.slave     io,
    output logic             carry_out,
    output logic [POS_W-1:0] pos
);

    localparam logic [POS_W:0]   ALPHA_E  = (POS_W+1)'(ALPHA);
    localparam logic [SYM_W:0]   BASE_E   = (SYM_W+1)'(BASE);
    localparam logic [SYM_W:0]   LIMIT_E  = (SYM_W+1)'(BASE + ALPHA);
    localparam logic [SYM_W-1:0] BASE_S   = SYM_W'(BASE);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAP  = 2'd1;
`ifndef ROTOR_INV_TABLE_EN
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [POS_W-1:0] LAST_IDX = POS_W'(ALPHA - 1);
`endif
    localparam logic [1:0] S_OUT  = 2'd3;

    // Operands are always already reduced, so one conditional subtract suffices.
    function automatic logic [POS_W-1:0] mod_add(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
        logic [POS_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_E) s = s - ALPHA_E;
        return s[POS_W-1:0];
    endfunction

    function automatic logic [POS_W-1:0] mod_sub(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
        logic [POS_W:0] s;
        s = {1'b0, a} + ALPHA_E - {1'b0, b};
        if (s >= ALPHA_E) s = s - ALPHA_E;
        return s[POS_W-1:0];
    endfunction

    function automatic logic idx_ok(input logic [POS_W-1:0] a);
        return {1'b0, a} < ALPHA_E;
    endfunction

    logic [1:0]       state;
    logic [POS_W-1:0] step_r;
    logic [POS_W-1:0] notch_r;
    logic [POS_W-1:0] wire_tbl [ALPHA];
    logic [POS_W-1:0] t_p1;
`ifdef ROTOR_INV_TABLE_EN
    logic [POS_W-1:0] inv_tbl [ALPHA];
    logic             dec_p1;
`else
    logic [POS_W-1:0] k;
    logic             scan_hit;
    logic [POS_W-1:0] scan_y;
`endif

    logic [SYM_W:0]   sym_e;
    logic             sym_ok;
    logic [POS_W-1:0] x_in;
    logic             we_ok;
    logic             ld_ok;
    logic             cfg_req;
    logic             is_idle;
    logic             accept;
    logic [POS_W-1:0] pos_adv;
    logic [POS_W-1:0] pos_map;
    logic [POS_W-1:0] t_in;
    logic [POS_W-1:0] map_src;
    logic [POS_W-1:0] map_y;

    assign io.in_ready = is_idle && !cfg_req;

    always_comb begin
        sym_e   = {1'b0, io.in_sym};
        sym_ok  = (sym_e >= BASE_E) && (sym_e < LIMIT_E);
        x_in    = POS_W'(sym_e - BASE_E);
        we_ok   = cfg_we && idx_ok(cfg_addr) && idx_ok(cfg_data);
        ld_ok   = cfg_load && idx_ok(cfg_start) && idx_ok(cfg_step) && idx_ok(cfg_notch);
        cfg_req = cfg_we || cfg_load;
        is_idle = (state == S_IDLE);
        accept  = io.in_valid && is_idle && !cfg_req;
        pos_adv = mod_add(pos, step_r);
        pos_map = io.in_adv ? pos_adv : pos;
        t_in    = mod_add(x_in, pos_map);
    end

    always_comb begin
        map_src = wire_tbl[t_p1];
`ifdef ROTOR_INV_TABLE_EN
        if (dec_p1) map_src = inv_tbl[t_p1];
`else
        scan_hit = (wire_tbl[k] == t_p1);
        scan_y   = mod_sub(k, pos);
`endif
        map_y = mod_sub(map_src, pos);
    end

    // Wiring storage: identity after reset, writable only while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ALPHA; i++) begin
                wire_tbl[i] <= POS_W'(i);
`ifdef ROTOR_INV_TABLE_EN
                inv_tbl[i]  <= POS_W'(i);
`endif
            end
        end else if (is_idle && we_ok) begin
            wire_tbl[cfg_addr] <= cfg_data;
`ifdef ROTOR_INV_TABLE_EN
            inv_tbl[cfg_data]  <= cfg_addr;
`endif
        end
    end

    // Accept stage: capture the table index to look up, already offset by the post-step position.
    always_ff @(posedge clk) begin
        if (accept && sym_ok) begin
            t_p1 <= t_in;
`ifdef ROTOR_INV_TABLE_EN
            dec_p1 <= io.in_dec;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pos          <= '0;
            step_r       <= POS_W'(1);
            notch_r      <= POS_W'(ALPHA - 1);
            cfg_err      <= 1'b0;
            carry_out    <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_sym   <= '0;
            io.out_err   <= 1'b0;
`ifndef ROTOR_INV_TABLE_EN
            k            <= '0;
`endif
        end else begin
            cfg_err   <= 1'b0;
            carry_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_req) begin
                        cfg_err <= (cfg_we && !we_ok) || (cfg_load && !ld_ok);
                        if (ld_ok) begin
                            pos     <= cfg_start;
                            step_r  <= cfg_step;
                            notch_r <= cfg_notch;
                        end
                    end else if (io.in_valid) begin
                        if (!sym_ok) begin
                            state        <= S_OUT;
                            io.out_valid <= 1'b1;
                            io.out_err   <= 1'b1;
                            io.out_sym   <= io.in_sym;
                        end else begin
                            if (io.in_adv) begin
                                pos       <= pos_adv;
                                carry_out <= (pos == notch_r);
                            end
`ifdef ROTOR_INV_TABLE_EN
                            state <= S_MAP;
`else
                            state <= io.in_dec ? S_SCAN : S_MAP;
                            k     <= '0;
`endif
                        end
                    end
                end
                S_MAP: begin
                    state        <= S_OUT;
                    io.out_valid <= 1'b1;
                    io.out_err   <= 1'b0;
                    io.out_sym   <= BASE_S + SYM_W'(map_y);
                end
`ifndef ROTOR_INV_TABLE_EN
                // One table entry per cycle; a missing target means the table is not a permutation.
                S_SCAN: begin
                    if (scan_hit) begin
                        state        <= S_OUT;
                        io.out_valid <= 1'b1;
                        io.out_err   <= 1'b0;
                        io.out_sym   <= BASE_S + SYM_W'(scan_y);
                    end else if (k == LAST_IDX) begin
                        state        <= S_OUT;
                        io.out_valid <= 1'b1;
                        io.out_err   <= 1'b1;
                        io.out_sym   <= '0;
                    end else begin
                        k <= k + POS_W'(1);
                    end
                end
`endif
                S_OUT: begin
                    if (io.out_ready) begin
                        state        <= S_IDLE;
                        io.out_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_param.sv
// Self-checking bench for rotor_param: directed vectors plus randomized symbols against a table-level model.
// Honours ROTOR_INV_TABLE_EN so the same bench covers both builds.
module tb_rotor_param;
    localparam int SYM_W = 8;
    localparam int ALPHA = 26;
    localparam int BASE  = 65;
    localparam int POS_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             cfg_we, cfg_load;
    logic [POS_W-1:0] cfg_addr, cfg_data, cfg_start, cfg_step, cfg_notch;
    logic             cfg_err, carry_out;
    logic [POS_W-1:0] pos;

    int n_pass  = 0;
    int n_total = 0;

    int m_wire [ALPHA];
    int m_inv  [ALPHA];
    int m_pos, m_step, m_notch;

    rotor_param_if #(.SYM_W(SYM_W)) bus ();

    rotor_param #(.SYM_W(SYM_W), .ALPHA(ALPHA), .BASE(BASE), .POS_W(POS_W)) dut (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_load(cfg_load), .cfg_start(cfg_start), .cfg_step(cfg_step), .cfg_notch(cfg_notch),
        .cfg_err(cfg_err), .io(bus), .carry_out(carry_out), .pos(pos)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < ALPHA; i++) begin
            m_wire[i] = i;
            m_inv[i]  = i;
        end
        m_pos = 0; m_step = 1; m_notch = ALPHA - 1;
    endtask

    // Rotor behaviour from the rules: step, offset by position, substitute, remove offset.
    task automatic model_sym(input int sym, input int dec, input int adv,
                             output int e_sym, output int e_err, output int e_lat,
                             output int e_carry, output int e_pos);
        int x, t, y, j;
        e_carry = 0; e_err = 0;
        if (sym < BASE || sym >= BASE + ALPHA) begin
            e_sym = sym; e_err = 1; e_lat = 1;
        end else begin
            x = sym - BASE;
            if (adv != 0) begin
                e_carry = (m_pos == m_notch) ? 1 : 0;
                m_pos = (m_pos + m_step) % ALPHA;
            end
            t = (x + m_pos) % ALPHA;
            if (dec == 0) begin
                y = (m_wire[t] - m_pos + ALPHA) % ALPHA;
                e_lat = 2; e_sym = BASE + y;
            end else begin
`ifdef ROTOR_INV_TABLE_EN
                y = (m_inv[t] - m_pos + ALPHA) % ALPHA;
                e_lat = 2; e_sym = BASE + y;
`else
                j = -1;
                for (int i = ALPHA - 1; i >= 0; i--) if (m_wire[i] == t) j = i;
                if (j < 0) begin
                    e_err = 1; e_sym = 0; e_lat = 1 + ALPHA;
                end else begin
                    y = (j - m_pos + ALPHA) % ALPHA;
                    e_lat = 2 + j; e_sym = BASE + y;
                end
`endif
            end
        end
        e_pos = m_pos;
    endtask

    task automatic cfg_write(input int addr, input int data, output logic err);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = POS_W'(addr); cfg_data = POS_W'(data);
        @(posedge clk); #1 cfg_we = 1'b0;
        @(negedge clk); err = cfg_err;
        if (addr < ALPHA && data < ALPHA) begin
            m_wire[addr] = data;
            m_inv[data]  = addr;
        end
    endtask

    task automatic cfg_ld(input int start, input int step, input int notch, output logic err);
        @(negedge clk);
        cfg_load = 1'b1; cfg_start = POS_W'(start); cfg_step = POS_W'(step); cfg_notch = POS_W'(notch);
        @(posedge clk); #1 cfg_load = 1'b0;
        @(negedge clk); err = cfg_err;
        if (start < ALPHA && step < ALPHA && notch < ALPHA) begin
            m_pos = start; m_step = step; m_notch = notch;
        end
    endtask

    // Latency counts cycles after the accept cycle until out_valid is seen; -1 on timeout.
    task automatic send(input logic [7:0] sym, input logic dec, input logic adv,
                        output logic [7:0] o_sym, output logic o_err, output int lat,
                        output logic carry, output logic [POS_W-1:0] p1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sym = sym; bus.in_dec = dec; bus.in_adv = adv;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk);
        lat = 1; carry = carry_out; p1 = pos;
        while (bus.out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk); lat++;
        end
        if (bus.out_valid !== 1'b1) lat = -1;
        o_sym = bus.out_sym; o_err = bus.out_err;
        if (bus.out_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] os; logic oe, cy; int lat; logic [POS_W-1:0] p1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_total++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.out_sym !== 8'h00 || bus.out_err !== 1'b0) $display("FAIL rst_out got %h/%b want 00/0", bus.out_sym, bus.out_err); else n_pass++;
        n_total++; if (cfg_err !== 1'b0 || carry_out !== 1'b0) $display("FAIL rst_pulses got %b/%b want 0/0", cfg_err, carry_out); else n_pass++;
        n_total++; if (pos !== 5'd0) $display("FAIL rst_pos got %0d want 0", pos); else n_pass++;
        send(8'h43, 1'b0, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'h43 || lat !== 2) $display("FAIL rst_identity got %h lat %0d want 43 lat 2", os, lat); else n_pass++;
    endtask

    task automatic test_vectors();
        string w = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
        logic [7:0] os; logic oe, cy, err; int lat; logic [POS_W-1:0] p1;
        int es, ee, el, ec, ep;
        for (int i = 0; i < ALPHA; i++) cfg_write(i, int'(w[i]) - BASE, err);
        cfg_ld(0, 1, ALPHA - 1, err);
        model_sym(8'h41, 0, 0, es, ee, el, ec, ep);
        send(8'h41, 1'b0, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'h45 || oe !== 1'b0) $display("FAIL vec1_sym got %h/%b want 45/0", os, oe); else n_pass++;
        n_total++; if (lat !== 2 || p1 !== 5'd0) $display("FAIL vec1_lat got lat %0d pos %0d want 2/0", lat, p1); else n_pass++;
        model_sym(8'h41, 0, 1, es, ee, el, ec, ep);
        send(8'h41, 1'b0, 1'b1, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'h4A || lat !== 2) $display("FAIL vec2_sym got %h lat %0d want 4a lat 2", os, lat); else n_pass++;
        n_total++; if (p1 !== 5'd1 || cy !== 1'b0) $display("FAIL vec2_pos got pos %0d carry %b want 1/0", p1, cy); else n_pass++;
        cfg_ld(0, 1, ALPHA - 1, err);
        model_sym(8'h45, 1, 0, es, ee, el, ec, ep);
        send(8'h45, 1'b1, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'h41 || lat !== 2) $display("FAIL vec3_decE got %h lat %0d want 41 lat 2", os, lat); else n_pass++;
        model_sym(8'h4A, 1, 0, es, ee, el, ec, ep);
        send(8'h4A, 1'b1, 1'b0, os, oe, lat, cy, p1);
`ifdef ROTOR_INV_TABLE_EN
        n_total++; if (os !== 8'h5A || lat !== 2) $display("FAIL vec3_decJ got %h lat %0d want 5a lat 2", os, lat); else n_pass++;
`else
        n_total++; if (os !== 8'h5A || lat !== 27) $display("FAIL vec3_decJ got %h lat %0d want 5a lat 27", os, lat); else n_pass++;
`endif
        cfg_ld(16, 1, 16, err);
        model_sym(8'h41, 0, 1, es, ee, el, ec, ep);
        send(8'h41, 1'b0, 1'b1, os, oe, lat, cy, p1);
        n_total++; if (cy !== 1'b1 || p1 !== 5'd17) $display("FAIL vec4_carry got carry %b pos %0d want 1/17", cy, p1); else n_pass++;
        n_total++; if (os !== 8'h44) $display("FAIL vec4_sym got %h want 44", os); else n_pass++;
    endtask

    task automatic test_errors();
        logic [7:0] os; logic oe, cy, err; int lat; logic [POS_W-1:0] p1, pb;
        int es, ee, el, ec, ep;
        pb = pos;
        model_sym(8'h61, 0, 1, es, ee, el, ec, ep);
        send(8'h61, 1'b0, 1'b1, os, oe, lat, cy, p1);
        n_total++; if (oe !== 1'b1 || os !== 8'h61) $display("FAIL err_range got %h/%b want 61/1", os, oe); else n_pass++;
        n_total++; if (p1 !== pb || pos !== pb || cy !== 1'b0) $display("FAIL err_range_pos got %0d carry %b want %0d/0", p1, cy, pb); else n_pass++;
        send(8'h40, 1'b1, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (oe !== 1'b1 || os !== 8'h40) $display("FAIL err_below got %h/%b want 40/1", os, oe); else n_pass++;
        cfg_write(26, 3, err);
        n_total++; if (err !== 1'b1) $display("FAIL cfg_addr_rej got %b want 1", err); else n_pass++;
        @(negedge clk);
        n_total++; if (cfg_err !== 1'b0) $display("FAIL cfg_err_pulse got %b want 0", cfg_err); else n_pass++;
        cfg_write(2, 30, err);
        n_total++; if (err !== 1'b1) $display("FAIL cfg_data_rej got %b want 1", err); else n_pass++;
        cfg_ld(3, 26, 4, err);
        n_total++; if (err !== 1'b1 || pos !== pb) $display("FAIL cfg_load_rej got err %b pos %0d want 1/%0d", err, pos, pb); else n_pass++;
        cfg_write(5, m_wire[5], err);
        n_total++; if (err !== 1'b0) $display("FAIL cfg_ok got %b want 0", err); else n_pass++;
        for (int a = 0; a < 3; a++) begin
            int x = (2 + a * 24 - m_pos + 2 * ALPHA) % ALPHA;
            model_sym(BASE + x, 0, 0, es, ee, el, ec, ep);
            send(8'(BASE + x), 1'b0, 1'b0, os, oe, lat, cy, p1);
            n_total++; if (os !== 8'(es) || oe !== 1'b0) $display("FAIL tbl_kept got %h want %h", os, 8'(es)); else n_pass++;
        end
    endtask

    task automatic test_random();
        int p [ALPHA];
        logic [7:0] os, sym; logic oe, cy, err, dec, adv; int lat; logic [POS_W-1:0] p1;
        int es, ee, el, ec, ep, j, tmp;
        for (int i = 0; i < ALPHA; i++) p[i] = i;
        for (int i = ALPHA - 1; i > 0; i--) begin
            j = $urandom_range(0, i); tmp = p[i]; p[i] = p[j]; p[j] = tmp;
        end
        for (int i = 0; i < ALPHA; i++) cfg_write(i, p[i], err);
        cfg_ld($urandom_range(0, ALPHA - 1), $urandom_range(0, ALPHA - 1), $urandom_range(0, ALPHA - 1), err);
        for (int n = 0; n < 40; n++) begin
            sym = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'(BASE + $urandom_range(0, ALPHA - 1));
            dec = 1'($urandom_range(0, 1));
            adv = 1'($urandom_range(0, 1));
            model_sym(sym, dec, adv, es, ee, el, ec, ep);
            send(sym, dec, adv, os, oe, lat, cy, p1);
            n_total++; if (os !== 8'(es)) $display("FAIL rnd_sym n=%0d in %h dec %b got %h want %h", n, sym, dec, os, 8'(es)); else n_pass++;
            n_total++; if (oe !== 1'(ee)) $display("FAIL rnd_err n=%0d got %b want %0d", n, oe, ee); else n_pass++;
            n_total++; if (lat !== el) $display("FAIL rnd_lat n=%0d got %0d want %0d", n, lat, el); else n_pass++;
            n_total++; if (cy !== 1'(ec)) $display("FAIL rnd_carry n=%0d got %b want %0d", n, cy, ec); else n_pass++;
            n_total++; if (p1 !== 5'(ep)) $display("FAIL rnd_pos n=%0d got %0d want %0d", n, p1, ep); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [7:0] os; logic oe, cy; int lat, x; logic [POS_W-1:0] p1;
        int es, ee, el, ec, ep;
        logic seen;
        x = (m_wire[ALPHA - 1] - m_pos + ALPHA) % ALPHA;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sym = 8'(BASE + x); bus.in_dec = 1'b1; bus.in_adv = 1'b0;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifndef ROTOR_INV_TABLE_EN
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL scan_busy got out_valid %b want 0", bus.out_valid); else n_pass++;
`endif
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        n_total++; if (bus.out_valid !== 1'b0 || pos !== 5'd0 || bus.in_ready !== 1'b1)
            $display("FAIL mid_rst got vld %b pos %0d rdy %b want 0/0/1", bus.out_valid, pos, bus.in_ready); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_total++; if (seen !== 1'b0) $display("FAIL mid_rst_stale got out_valid 1 want 0"); else n_pass++;
        model_sym(8'h51, 0, 0, es, ee, el, ec, ep);
        send(8'h51, 1'b0, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'h51 || lat !== 2) $display("FAIL mid_rst_fwd got %h lat %0d want 51 lat 2", os, lat); else n_pass++;
        model_sym(8'h5A, 1, 0, es, ee, el, ec, ep);
        send(8'h5A, 1'b1, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'h5A || lat !== el) $display("FAIL mid_rst_bwd got %h lat %0d want 5a lat %0d", os, lat, el); else n_pass++;
    endtask

    task automatic test_cfg_both();
        logic [7:0] os; logic oe, cy; int lat, a, d, s, x; logic [POS_W-1:0] p1;
        int es, ee, el, ec, ep;
        a = $urandom_range(0, ALPHA - 1); d = $urandom_range(0, ALPHA - 1); s = $urandom_range(0, ALPHA - 1);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sym = 8'h41; bus.in_dec = 1'b0; bus.in_adv = 1'b1;
        cfg_we = 1'b1; cfg_addr = 5'(a); cfg_data = 5'(d);
        cfg_load = 1'b1; cfg_start = 5'(s); cfg_step = 5'd2; cfg_notch = 5'd0;
        #1;
        n_total++; if (bus.in_ready !== 1'b0) $display("FAIL both_prio got in_ready %b want 0", bus.in_ready); else n_pass++;
        @(posedge clk); #1 begin cfg_we = 1'b0; cfg_load = 1'b0; bus.in_valid = 1'b0; end
        m_wire[a] = d; m_inv[d] = a; m_pos = s; m_step = 2; m_notch = 0;
        @(negedge clk);
        n_total++; if (pos !== 5'(s) || cfg_err !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL both_load got pos %0d err %b vld %b want %0d/0/0", pos, cfg_err, bus.out_valid, s); else n_pass++;
        x = (a - s + ALPHA) % ALPHA;
        model_sym(BASE + x, 0, 0, es, ee, el, ec, ep);
        send(8'(BASE + x), 1'b0, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'(es)) $display("FAIL both_write got %h want %h", os, 8'(es)); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] cap; int lat, x;
        int es, ee, el, ec, ep;
        x = $urandom_range(0, ALPHA - 1);
        model_sym(BASE + x, 0, 1, es, ee, el, ec, ep);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_sym = 8'(BASE + x); bus.in_dec = 1'b0; bus.in_adv = 1'b1;
        @(posedge clk); #1 bus.in_valid = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (bus.out_valid !== 1'b1 && lat < 60);
        n_total++; if (bus.out_valid !== 1'b1 || lat !== 2) $display("FAIL bp_first got vld %b lat %0d want 1 lat 2", bus.out_valid, lat); else n_pass++;
        cap = bus.out_sym;
        n_total++; if (cap !== 8'(es)) $display("FAIL bp_sym got %h want %h", cap, 8'(es)); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1 begin
                cfg_we = (c == 0); cfg_addr = 5'd26; cfg_data = 5'd1;
            end
            @(negedge clk);
            n_total++; if (bus.out_valid !== 1'b1 || bus.out_sym !== cap || bus.in_ready !== 1'b0 || cfg_err !== 1'b0)
                $display("FAIL bp_hold c=%0d got vld %b sym %h rdy %b cfgerr %b want 1/%h/0/0", c, bus.out_valid, bus.out_sym, bus.in_ready, cfg_err, cap);
            else n_pass++;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL bp_release got vld %b rdy %b want 0/1", bus.out_valid, bus.in_ready); else n_pass++;
    endtask

    task automatic test_not_found();
        logic [7:0] os; logic oe, cy, err; int lat; logic [POS_W-1:0] p1;
        int es, ee, el, ec, ep;
        for (int i = 0; i < ALPHA; i++) cfg_write(i, (i == 7) ? 8 : i, err);
        cfg_ld(3, 1, ALPHA - 1, err);
        model_sym(8'h45, 1, 0, es, ee, el, ec, ep);
        send(8'h45, 1'b1, 1'b0, os, oe, lat, cy, p1);
`ifndef ROTOR_INV_TABLE_EN
        n_total++; if (oe !== 1'b1 || os !== 8'h00 || lat !== 27) $display("FAIL nf_miss got %h/%b lat %0d want 00/1 lat 27", os, oe, lat); else n_pass++;
`endif
        n_total++; if (os !== 8'(es) || oe !== 1'(ee) || lat !== el) $display("FAIL nf_model got %h/%b lat %0d want %h/%0d lat %0d", os, oe, lat, 8'(es), ee, el); else n_pass++;
        model_sym(8'h46, 1, 0, es, ee, el, ec, ep);
        send(8'h46, 1'b1, 1'b0, os, oe, lat, cy, p1);
        n_total++; if (os !== 8'(es) || oe !== 1'(ee) || lat !== el) $display("FAIL nf_dup got %h/%b lat %0d want %h/%0d lat %0d", os, oe, lat, 8'(es), ee, el); else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        cfg_we = 1'b0; cfg_load = 1'b0;
        cfg_addr = '0; cfg_data = '0; cfg_start = '0; cfg_step = '0; cfg_notch = '0;
        bus.in_valid = 1'b0; bus.in_sym = '0; bus.in_dec = 1'b0; bus.in_adv = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_vectors();
        test_errors();
        test_random();
        test_reset_mid_scan();
        test_cfg_both();
        test_backpressure();
        test_not_found();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
